// File: rtl/cpu_types_pkg.sv
// Shared core types: RAM handshake states, data words, arbiter states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arbstate_t;

endpackage

// File: rtl/arb_streak_ctr.sv
// Saturating count of consecutive data wins while a fetch is waiting.
module arb_streak_ctr #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] count,
    output logic       sat
);

    localparam logic [3:0] MAX = 4'(MAX_DSTREAK);

    assign sat = (count == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (inc && !sat) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between fetch and memory stages; data has priority,
// bounded by a streak counter so fetch cannot starve indefinitely.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_DSTREAK = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ram_err
);

    arbstate_t  state;
    logic [3:0] dstreak;
    logic       sat;
    logic       acc;
    logic       dreq;
    logic       d_done;
    logic       i_done;

    assign acc    = (ramstate == ACCESS);
    assign dreq   = dREN | dWEN;
    assign d_done = (state == DGNT) && acc;
    assign i_done = (state == IGNT) && acc;

    arb_streak_ctr #(
        .MAX_DSTREAK(MAX_DSTREAK)
    ) u_streak (
        .clk  (CLK),
        .rst_n(nRST),
        .inc  (d_done && iREN),
        .clr  ((d_done && !iREN) || i_done),
        .count(dstreak),
        .sat  (sat)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            ram_err <= 1'b0;
        end else begin
            if (ramstate == ERROR) begin
                ram_err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (dreq && !(iREN && sat)) begin
                        state <= DGNT;
                    end else if (iREN) begin
                        state <= IGNT;
                    end
                end
                IGNT: begin
                    if (acc || !iREN) begin
                        state <= IDLE;
                    end
                end
                DGNT: begin
                    if (acc || !dreq) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Load data is passed through unconditionally; only valid when wait is low.
    assign iload = ramload;
    assign dload = ramload;

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = iREN;
        dwait    = dreq;
        unique case (state)
            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = !acc;
            end
            DGNT: begin
                ramWEN   = dWEN;
                ramREN   = dREN && !dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = !acc;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of mem_arbiter grant sequencing, priority and streak limit.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ram_err;

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(.MAX_DSTREAK(4)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iwait   (iwait),
        .iload   (iload),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dwait   (dwait),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate),
        .ram_err (ram_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] st();
        return 32'(dut.state);
    endfunction

    initial begin
        nRST = 1'b0;
        iREN = 1'b0; iaddr = 32'd0;
        dREN = 1'b0; dWEN = 1'b0;
        daddr = 32'd0; dstore = 32'd0;
        ramload = 32'd0; ramstate = FREE;
        #12;
        settle();
        chk("rst_state", st(), 32'(IDLE));
        chk("rst_streak", 32'(dut.dstreak), 32'd0);
        chk("rst_err", 32'(ram_err), 32'd0);
        chk("rst_ren", 32'(ramREN), 32'd0);
        nRST = 1'b1;
        tick();

        // 1: single fetch, ACCESS on second grant cycle
        iREN = 1'b1; iaddr = 32'h40;
        settle();
        chk("t1_idle_iwait", 32'(iwait), 32'd1);
        chk("t1_idle_ren", 32'(ramREN), 32'd0);
        tick();
        ramstate = BUSY;
        settle();
        chk("t1_ignt", st(), 32'(IGNT));
        chk("t1_ren", 32'(ramREN), 32'd1);
        chk("t1_addr", ramaddr, 32'h40);
        chk("t1_iwait_busy", 32'(iwait), 32'd1);
        tick();
        ramstate = ACCESS; ramload = 32'h8C010004;
        settle();
        chk("t1_iwait_acc", 32'(iwait), 32'd0);
        chk("t1_iload", iload, 32'h8C010004);
        tick();
        iREN = 1'b0; ramstate = FREE;
        settle();
        chk("t1_bubble", st(), 32'(IDLE));
        chk("t1_bubble_ren", 32'(ramREN), 32'd0);
        tick();

        // 2: simultaneous requests, data first
        iREN = 1'b1; iaddr = 32'h44;
        dREN = 1'b1; daddr = 32'h100;
        tick();
        ramstate = BUSY;
        settle();
        chk("t2_dgnt", st(), 32'(DGNT));
        chk("t2_addr", ramaddr, 32'h100);
        chk("t2_ren", 32'(ramREN), 32'd1);
        chk("t2_iwait", 32'(iwait), 32'd1);
        chk("t2_dwait", 32'(dwait), 32'd1);
        tick();
        ramstate = ACCESS; ramload = 32'h11112222;
        settle();
        chk("t2_dwait_acc", 32'(dwait), 32'd0);
        chk("t2_dload", dload, 32'h11112222);
        chk("t2_iwait_acc", 32'(iwait), 32'd1);
        tick();
        dREN = 1'b0; ramstate = FREE;
        settle();
        chk("t2_bubble", st(), 32'(IDLE));
        chk("t2_streak1", 32'(dut.dstreak), 32'd1);
        chk("t2_bubble_iwait", 32'(iwait), 32'd1);
        tick();
        ramstate = ACCESS;
        settle();
        chk("t2_ignt", st(), 32'(IGNT));
        chk("t2_iaddr", ramaddr, 32'h44);
        chk("t2_iwait_done", 32'(iwait), 32'd0);
        tick();
        iREN = 1'b0; ramstate = FREE;
        settle();
        chk("t2_streak_clr", 32'(dut.dstreak), 32'd0);
        tick();

        // 3: write wins over read when both asserted
        dREN = 1'b1; dWEN = 1'b1;
        dstore = 32'hDEADBEEF; daddr = 32'h200;
        tick();
        ramstate = BUSY;
        settle();
        chk("t3_wen", 32'(ramWEN), 32'd1);
        chk("t3_ren", 32'(ramREN), 32'd0);
        chk("t3_store", ramstore, 32'hDEADBEEF);
        chk("t3_addr", ramaddr, 32'h200);
        chk("t3_dwait_busy", 32'(dwait), 32'd1);
        tick();
        ramstate = ACCESS;
        settle();
        chk("t3_dwait_acc", 32'(dwait), 32'd0);
        tick();
        dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        settle();
        chk("t3_idle", st(), 32'(IDLE));
        tick();

        // 4: streak limit forces a fetch grant
        iREN = 1'b1; iaddr = 32'h80;
        dREN = 1'b1; daddr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            tick();
            ramstate = ACCESS;
            settle();
            chk("t4_dgnt", st(), 32'(DGNT));
            chk("t4_streak_pre", 32'(dut.dstreak), 32'(k));
            tick();
            ramstate = FREE;
            settle();
            chk("t4_bubble", st(), 32'(IDLE));
            chk("t4_streak_post", 32'(dut.dstreak), 32'(k + 1));
        end
        tick();
        ramstate = ACCESS;
        settle();
        chk("t4_forced_ignt", st(), 32'(IGNT));
        chk("t4_iaddr", ramaddr, 32'h80);
        chk("t4_dwait", 32'(dwait), 32'd1);
        tick();
        iREN = 1'b0; ramstate = FREE;
        settle();
        chk("t4_streak_clr", 32'(dut.dstreak), 32'd0);
        tick();
        ramstate = ACCESS;
        settle();
        chk("t4_dgnt_again", st(), 32'(DGNT));
        tick();
        dREN = 1'b0; ramstate = FREE;
        settle();
        chk("t4_end_streak", 32'(dut.dstreak), 32'd0);
        tick();

        // 5: ERROR is not completion and latches ram_err
        dREN = 1'b1; daddr = 32'h400;
        tick();
        ramstate = ERROR;
        settle();
        chk("t5_dwait_err0", 32'(dwait), 32'd1);
        chk("t5_err_pre", 32'(ram_err), 32'd0);
        tick();
        settle();
        chk("t5_err_set", 32'(ram_err), 32'd1);
        chk("t5_dwait_err1", 32'(dwait), 32'd1);
        chk("t5_hold", st(), 32'(DGNT));
        tick();
        settle();
        chk("t5_dwait_err2", 32'(dwait), 32'd1);
        tick();
        ramstate = ACCESS;
        settle();
        chk("t5_dwait_acc", 32'(dwait), 32'd0);
        tick();
        dREN = 1'b0; ramstate = FREE;
        settle();
        chk("t5_idle", st(), 32'(IDLE));
        chk("t5_err_sticky", 32'(ram_err), 32'd1);
        tick();

        // 6: reset mid-transaction
        iREN = 1'b1; dREN = 1'b1; daddr = 32'h500;
        tick();
        ramstate = ACCESS;
        tick();
        ramstate = FREE;
        tick();
        ramstate = BUSY;
        settle();
        chk("t6_dgnt", st(), 32'(DGNT));
        chk("t6_ren", 32'(ramREN), 32'd1);
        chk("t6_streak", 32'(dut.dstreak), 32'd1);
        nRST = 1'b0;
        settle();
        chk("t6_rst_ren", 32'(ramREN), 32'd0);
        chk("t6_rst_wen", 32'(ramWEN), 32'd0);
        chk("t6_rst_state", st(), 32'(IDLE));
        chk("t6_rst_streak", 32'(dut.dstreak), 32'd0);
        chk("t6_rst_err", 32'(ram_err), 32'd0);
        chk("t6_rst_dwait", 32'(dwait), 32'd1);
        iREN = 1'b0; ramstate = FREE;
        #2;
        nRST = 1'b1;
        tick();
        settle();
        chk("t6_resume", st(), 32'(DGNT));
        chk("t6_resume_addr", ramaddr, 32'h500);
        dREN = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
